// File: rtl/clk_div_pkg.sv
// clk_div_pkg: default widths, reset divide value and the per-channel config record
// shared by the clock divider bank and its channels.
package clk_div_pkg;

    localparam int NCH_DEF       = 4;
    localparam int DIVW_DEF      = 16;
    localparam int CHW_DEF       = 2;
    localparam int DIV_RESET_DEF = 125;

    typedef struct packed {
        logic [DIVW_DEF-1:0] div;
        logic [DIVW_DEF-1:0] shadow;
        logic                pend;
    } chan_cfg_t;

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel -- up-counter with exact terminal compare, tick strobe,
// toggling clk_out and a shadowed divide value. Optional sync port under CLK_DIV_SYNC_EN.
module clk_div_chan import clk_div_pkg::*; #(
    parameter int              DIVW      = DIVW_DEF,
    parameter logic [DIVW-1:0] DIV_RESET = DIVW'(DIV_RESET_DEF)
) (
    input  logic            clk_in,
    input  logic            reset,
    input  logic            en,
`ifdef CLK_DIV_SYNC_EN
    input  logic            sync,
`endif
    input  logic            wr,
    input  logic [DIVW-1:0] wr_div,
    output logic            pend,
    output logic            tick,
    output logic            clk_out
);

    logic [DIVW-1:0] cnt;
    logic [DIVW-1:0] div;
    logic [DIVW-1:0] shadow;
    logic            restart;

`ifdef CLK_DIV_SYNC_EN
    assign restart = sync | ~en;
`else
    assign restart = ~en;
`endif

    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt     <= '0;
            div     <= DIV_RESET;
            shadow  <= DIV_RESET;
            pend    <= 1'b0;
            tick    <= 1'b0;
            clk_out <= 1'b0;
        end else begin
            // A held or realigned channel sits at phase zero, so a pending value is safe to take now.
            if (restart) begin
                cnt     <= '0;
                tick    <= 1'b0;
                clk_out <= 1'b0;
                if (pend) begin
                    div  <= shadow;
                    pend <= 1'b0;
                end
            end else if (cnt == div) begin
                cnt     <= '0;
                tick    <= 1'b1;
                clk_out <= ~clk_out;
                if (pend) begin
                    div  <= shadow;
                    pend <= 1'b0;
                end
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
            end
            // wr is only raised while pend is clear, so it never collides with the apply above.
            if (wr) begin
                shadow <= wr_div;
                pend   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: NCH independent programmable clock dividers with a shared config port.
// Define CLK_DIV_SYNC_EN to add the sync_in bank phase-realign input.
module clk_div_bank import clk_div_pkg::*; #(
    parameter int NCH       = NCH_DEF,
    parameter int DIVW      = DIVW_DEF,
    parameter int DIV_RESET = DIV_RESET_DEF,
    parameter int CHW       = CHW_DEF
) (
    input  logic            clk_in,
    input  logic            reset,
    input  logic [NCH-1:0]  en,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [CHW-1:0]  cfg_chan,
    input  logic [DIVW-1:0] cfg_div,
    output logic [NCH-1:0]  tick,
    output logic [NCH-1:0]  clk_out
`ifdef CLK_DIV_SYNC_EN
    ,
    input  logic            sync_in
`endif
);

    logic [NCH-1:0]     pend;
    logic [NCH-1:0]     wr;
    logic [2**CHW-1:0]  pend_pad;

    // Unpopulated channel slots read as never pending, so writes to them are accepted and dropped.
    always_comb begin
        pend_pad = '0;
        for (int i = 0; i < NCH; i++) begin
            pend_pad[i] = pend[i];
        end
    end

    assign cfg_ready = ~pend_pad[cfg_chan];

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        assign wr[i] = cfg_valid & cfg_ready & (cfg_chan == CHW'(i));

        clk_div_chan #(
            .DIVW      (DIVW),
            .DIV_RESET (DIVW'(DIV_RESET))
        ) u_chan (
            .clk_in  (clk_in),
            .reset   (reset),
            .en      (en[i]),
`ifdef CLK_DIV_SYNC_EN
            .sync    (sync_in),
`endif
            .wr      (wr[i]),
            .wr_div  (cfg_div),
            .pend    (pend[i]),
            .tick    (tick[i]),
            .clk_out (clk_out[i])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: randomized and directed checks of clk_div_bank against a countdown
// reference model of each channel; a second NCH=3 instance covers out-of-range cfg_chan.
`timescale 1ns/1ps
module tb_clk_div_bank;
    import clk_div_pkg::*;

    localparam int NCH = 4;
    localparam int DRST = 125;

    logic        clk_in = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  en = '0;
    logic        cfg_valid = 1'b0;
    logic [1:0]  cfg_chan = '0;
    logic [15:0] cfg_div = '0;
    logic        sync_drv = 1'b0;
    logic        cfg_ready;
    logic [3:0]  tick;
    logic [3:0]  clk_out;

    logic [2:0]  en3 = '0;
    logic        cfg_valid3 = 1'b0;
    logic [1:0]  cfg_chan3 = '0;
    logic [15:0] cfg_div3 = '0;
    logic        cfg_ready3;
    logic [2:0]  tick3;
    logic [2:0]  clk_out3;

    int errors = 0;
    int checks = 0;

    chan_cfg_t  m_cfg [NCH];
    int         m_left [NCH];
    logic [3:0] m_tick;
    logic [3:0] m_clk;

    always #5 clk_in = ~clk_in;

    clk_div_bank u_dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_div   (cfg_div),
        .tick      (tick),
        .clk_out   (clk_out)
`ifdef CLK_DIV_SYNC_EN
        ,
        .sync_in   (sync_drv)
`endif
    );

    clk_div_bank #(.NCH(3), .DIVW(16), .DIV_RESET(4), .CHW(2)) u_dut3 (
        .clk_in    (clk_in),
        .reset     (reset),
        .en        (en3),
        .cfg_valid (cfg_valid3),
        .cfg_ready (cfg_ready3),
        .cfg_chan  (cfg_chan3),
        .cfg_div   (cfg_div3),
        .tick      (tick3),
        .clk_out   (clk_out3)
`ifdef CLK_DIV_SYNC_EN
        ,
        .sync_in   (1'b0)
`endif
    );

    // Model: each channel counts down the enabled edges left until its next tick.
    task automatic model_step();
        int  c;
        bit  acc;
        c   = int'(cfg_chan);
        acc = cfg_valid && (c >= NCH || !m_cfg[c].pend);
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                m_cfg[i].div    = 16'(DRST);
                m_cfg[i].shadow = 16'(DRST);
                m_cfg[i].pend   = 1'b0;
                m_left[i]       = DRST + 1;
                m_tick[i]       = 1'b0;
                m_clk[i]        = 1'b0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (sync_drv || !en[i]) begin
                    if (m_cfg[i].pend) begin
                        m_cfg[i].div  = m_cfg[i].shadow;
                        m_cfg[i].pend = 1'b0;
                    end
                    m_left[i] = int'(m_cfg[i].div) + 1;
                    m_tick[i] = 1'b0;
                    m_clk[i]  = 1'b0;
                end else begin
                    m_left[i] = m_left[i] - 1;
                    if (m_left[i] == 0) begin
                        m_tick[i] = 1'b1;
                        m_clk[i]  = ~m_clk[i];
                        if (m_cfg[i].pend) begin
                            m_cfg[i].div  = m_cfg[i].shadow;
                            m_cfg[i].pend = 1'b0;
                        end
                        m_left[i] = int'(m_cfg[i].div) + 1;
                    end else begin
                        m_tick[i] = 1'b0;
                    end
                end
            end
            if (acc && c < NCH) begin
                m_cfg[c].shadow = cfg_div;
                m_cfg[c].pend   = 1'b1;
            end
        end
    endtask

    function automatic logic exp_ready();
        if (int'(cfg_chan) >= NCH) return 1'b1;
        return !m_cfg[cfg_chan].pend;
    endfunction

    task automatic cycle();
        @(posedge clk_in);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = '1; cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_div = 16'd5;
        repeat (3) cycle();
        checks++;
        if (tick !== 4'b0 || clk_out !== 4'b0) begin
            errors++;
            $display("FAIL reset_outputs tick=%b clk_out=%b required 0000 0000", tick, clk_out);
        end
        reset = 1'b0; en = '0; cfg_valid = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            cfg_chan = 2'(c);
            #1;
            checks++;
            if (cfg_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_ready chan=%0d cfg_ready=%b required 1", c, cfg_ready);
            end
        end
    endtask

    task automatic test_div_reset();
        int e = 0, first = -1, nticks = 0;
        en = 4'b0001;
        for (int k = 0; k < 504; k++) begin
            cycle(); e++;
            checks++;
            if (tick !== m_tick || clk_out !== m_clk) begin
                errors++;
                $display("FAIL div_reset_cycle t=%0t tick=%b clk_out=%b required %b %b", $time, tick, clk_out, m_tick, m_clk);
            end
            if (tick[0]) begin
                nticks++;
                if (first < 0) first = e;
            end
        end
        checks++;
        if (first !== 126) begin
            errors++;
            $display("FAIL div_reset_first first_tick_edge=%0d required 126", first);
        end
        checks++;
        if (nticks !== 4) begin
            errors++;
            $display("FAIL div_reset_count ticks=%0d required 4", nticks);
        end
    endtask

    task automatic test_reload();
        int e = 0, first = -1, second = -1, low = 0;
        en[1] = 1'b1;
        for (int k = 0; k < 40; k++) begin
            cycle(); e++;
            checks++;
            if (tick !== m_tick || clk_out !== m_clk) begin
                errors++;
                $display("FAIL reload_pre t=%0t tick=%b clk_out=%b required %b %b", $time, tick, clk_out, m_tick, m_clk);
            end
        end
        cfg_chan = 2'd1; cfg_div = 16'd3; cfg_valid = 1'b1;
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reload_accept cfg_ready=%b required 1", cfg_ready);
        end
        cycle(); e++;
        cfg_valid = 1'b0;
        for (int k = 0; k < 120; k++) begin
            #1;
            if (cfg_ready === 1'b0) low++;
            checks++;
            if (cfg_ready !== exp_ready()) begin
                errors++;
                $display("FAIL reload_ready t=%0t cfg_ready=%b required %b", $time, cfg_ready, exp_ready());
            end
            cycle(); e++;
            checks++;
            if (tick !== m_tick || clk_out !== m_clk) begin
                errors++;
                $display("FAIL reload_cycle t=%0t tick=%b clk_out=%b required %b %b", $time, tick, clk_out, m_tick, m_clk);
            end
            if (tick[1]) begin
                if (first < 0) first = e;
                else if (second < 0) second = e;
            end
        end
        checks++;
        if (first !== 126 || second !== 130) begin
            errors++;
            $display("FAIL reload_ticks first=%0d second=%0d required 126 130", first, second);
        end
        checks++;
        if (low !== 85) begin
            errors++;
            $display("FAIL reload_ready_low cycles=%0d required 85", low);
        end
    endtask

    task automatic test_d_zero();
        logic prev;
        cfg_chan = 2'd2; cfg_div = 16'd0; cfg_valid = 1'b1;
        cycle();
        cfg_valid = 1'b0;
        cycle();
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL dzero_applied cfg_ready=%b required 1", cfg_ready);
        end
        en[2] = 1'b1;
        cycle();
        prev = clk_out[2];
        for (int k = 0; k < 20; k++) begin
            cycle();
            checks++;
            if (tick[2] !== 1'b1 || clk_out[2] !== ~prev) begin
                errors++;
                $display("FAIL dzero_cycle t=%0t tick2=%b clk_out2=%b required 1 %b", $time, tick[2], clk_out[2], ~prev);
            end
            prev = clk_out[2];
            checks++;
            if (tick !== m_tick || clk_out !== m_clk) begin
                errors++;
                $display("FAIL dzero_model t=%0t tick=%b clk_out=%b required %b %b", $time, tick, clk_out, m_tick, m_clk);
            end
        end
    endtask

    task automatic test_drop_en();
        int e = 0, first = -1;
        en[3] = 1'b1;
        repeat (30) cycle();
        cfg_chan = 2'd3; cfg_div = 16'd3; cfg_valid = 1'b1;
        cycle();
        cfg_valid = 1'b0; en[3] = 1'b0;
        cycle();
        checks++;
        if (tick[3] !== 1'b0 || clk_out[3] !== 1'b0) begin
            errors++;
            $display("FAIL drop_en tick3=%b clk_out3=%b required 0 0", tick[3], clk_out[3]);
        end
        cycle();
        en[3] = 1'b1;
        for (int k = 0; k < 20 && first < 0; k++) begin
            cycle(); e++;
            checks++;
            if (tick !== m_tick || clk_out !== m_clk) begin
                errors++;
                $display("FAIL drop_en_model t=%0t tick=%b clk_out=%b required %b %b", $time, tick, clk_out, m_tick, m_clk);
            end
            if (tick[3]) first = e;
        end
        checks++;
        if (first !== 4) begin
            errors++;
            $display("FAIL drop_en_first first_tick_edge=%0d required 4", first);
        end
    endtask

    task automatic test_dmax();
        int nt = 0;
        en[0] = 1'b0;
        cfg_chan = 2'd0; cfg_div = 16'hFFFF; cfg_valid = 1'b1;
        #1;
        checks++;
        if (cfg_ready !== exp_ready()) begin
            errors++;
            $display("FAIL dmax_ready cfg_ready=%b required %b", cfg_ready, exp_ready());
        end
        cycle();
        cfg_valid = 1'b0;
        cycle();
        en[0] = 1'b1;
        for (int k = 0; k < 600; k++) begin
            cycle();
            if (tick[0]) nt++;
            checks++;
            if (tick !== m_tick || clk_out !== m_clk) begin
                errors++;
                $display("FAIL dmax_model t=%0t tick=%b clk_out=%b required %b %b", $time, tick, clk_out, m_tick, m_clk);
            end
        end
        checks++;
        if (nt !== 0) begin
            errors++;
            $display("FAIL dmax_no_tick ticks=%0d required 0", nt);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 15) == 0) en = 4'($urandom);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_chan  = 2'($urandom);
            cfg_div   = 16'($urandom_range(0, 7));
`ifdef CLK_DIV_SYNC_EN
            sync_drv  = ($urandom_range(0, 60) == 0);
`endif
            #1;
            checks++;
            if (cfg_ready !== exp_ready()) begin
                errors++;
                $display("FAIL random_ready t=%0t chan=%0d cfg_ready=%b required %b", $time, cfg_chan, cfg_ready, exp_ready());
            end
            cycle();
            checks++;
            if (tick !== m_tick || clk_out !== m_clk) begin
                errors++;
                $display("FAIL random_cycle t=%0t tick=%b clk_out=%b required %b %b", $time, tick, clk_out, m_tick, m_clk);
            end
        end
        cfg_valid = 1'b0;
        sync_drv  = 1'b0;
    endtask

    task automatic test_reset_mid();
        int e = 0, first = -1;
        en = '1; cfg_valid = 1'b1; cfg_chan = 2'($urandom); cfg_div = 16'd2;
        repeat (5) cycle();
        reset = 1'b1;
        cycle();
        checks++;
        if (tick !== 4'b0 || clk_out !== 4'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs tick=%b clk_out=%b required 0000 0000", tick, clk_out);
        end
        reset = 1'b0; cfg_valid = 1'b0; en = '0;
        for (int c = 0; c < NCH; c++) begin
            cfg_chan = 2'(c);
            #1;
            checks++;
            if (cfg_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_mid_ready chan=%0d cfg_ready=%b required 1", c, cfg_ready);
            end
        end
        en = 4'b0001;
        for (int k = 0; k < 130 && first < 0; k++) begin
            cycle(); e++;
            if (tick[0]) first = e;
        end
        checks++;
        if (first !== 126) begin
            errors++;
            $display("FAIL reset_mid_period first_tick_edge=%0d required 126", first);
        end
        en = '0;
        cycle();
    endtask

    task automatic test_oob();
        logic [2:0] exp;
        en3 = 3'b001; cfg_valid3 = 1'b1; cfg_chan3 = 2'd3; cfg_div3 = 16'd1;
        for (int e = 1; e <= 30; e++) begin
            #1;
            checks++;
            if (cfg_ready3 !== 1'b1) begin
                errors++;
                $display("FAIL oob_ready cfg_ready=%b required 1", cfg_ready3);
            end
            cycle();
            exp = (e % 5 == 0) ? 3'b001 : 3'b000;
            checks++;
            if (tick3 !== exp) begin
                errors++;
                $display("FAIL oob_tick edge=%0d tick=%b required %b", e, tick3, exp);
            end
        end
        cfg_valid3 = 1'b0; en3 = '0;
    endtask

`ifdef CLK_DIV_SYNC_EN
    task automatic test_sync();
        int e = 0;
        en = '0;
        cfg_chan = 2'd0; cfg_div = 16'd3; cfg_valid = 1'b1;
        cycle();
        cfg_chan = 2'd1; cfg_div = 16'd7;
        cycle();
        cfg_valid = 1'b0;
        cycle();
        en = 4'b0011;
        repeat (13) cycle();
        sync_drv = 1'b1;
        cycle();
        sync_drv = 1'b0;
        checks++;
        if (tick !== 4'b0 || clk_out !== 4'b0) begin
            errors++;
            $display("FAIL sync_align tick=%b clk_out=%b required 0000 0000", tick, clk_out);
        end
        for (int k = 0; k < 32; k++) begin
            cycle(); e++;
            checks++;
            if (tick[1:0] !== {(e % 8 == 0), (e % 4 == 0)}) begin
                errors++;
                $display("FAIL sync_ticks edge=%0d tick=%b required %b", e, tick[1:0], {(e % 8 == 0), (e % 4 == 0)});
            end
        end
        reset = 1'b1; sync_drv = 1'b1;
        cycle();
        reset = 1'b0; sync_drv = 1'b0;
        checks++;
        if (tick !== 4'b0 || clk_out !== 4'b0) begin
            errors++;
            $display("FAIL sync_reset tick=%b clk_out=%b required 0000 0000", tick, clk_out);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_div_reset();
        test_reload();
        test_d_zero();
        test_drop_en();
        test_dmax();
        test_random();
        test_reset_mid();
        test_oob();
`ifdef CLK_DIV_SYNC_EN
        test_sync();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
